wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back stage plus architectural register file of the MIPS32 pipeline.
//  Consumes the MEM/WB pipeline-register outputs and selects the write-back value.
//  Commits that value into the 32x32 register file and serves two combinational
//  read ports to the ID stage.
//  Keeps a free-running count of committed register writes for debug/perf.
// PARAMETERS
//  S_WB      2   width of WB control bundle; [0]=RegWrite, [1]=MemtoReg
//  SIZE_DATA 32  datapath / register width
//  SIZE_ADDR 5   register index width; depth = 2**SIZE_ADDR
//  CNT_W     32  width of committed-write counter
// PORTS
//  clk                    in   1          rising-edge clock, single domain
//  rst_n                  in   1          asynchronous active-low reset
//  WB_in                  in   S_WB       WB control from MEM/WB
//  datoLeido_in           in   SIZE_DATA  load data from MEM/WB
//  direccion_in           in   SIZE_DATA  ALU result from MEM/WB
//  direccionRegistro_in   in   SIZE_ADDR  destination register from MEM/WB
//  rs_addr                in   SIZE_ADDR  read port A index (ID stage)
//  rt_addr                in   SIZE_ADDR  read port B index (ID stage)
//  rs_data                out  SIZE_DATA  read port A data, combinational
//  rt_data                out  SIZE_DATA  read port B data, combinational
//  wb_data                out  SIZE_DATA  selected write-back value (to forwarding unit)
//  wb_we                  out  1          effective write enable (RegWrite && dest!=0)
//  wr_count               out  CNT_W      number of committed writes
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers and wr_count cleared to 0 immediately;
//    rs_data/rt_data therefore read 0; writes ignored while rst_n=0.
//  - wb_data = WB_in[1] ? datoLeido_in : direccion_in (combinational).
//  - wb_we = WB_in[0] && (direccionRegistro_in != 0) (combinational).
//  - Write: at posedge clk with wb_we=1, reg[direccionRegistro_in] <= wb_data; latency
//    1 edge. Writes to $0 are discarded; $0 always reads 0, including after reset.
//  - wr_count increments by 1 on every edge where a write commits; wraps
//    2**CNT_W-1 -> 0 silently. Writes to $0 do not count.
//  - Reads: asynchronous; rs_data=reg[rs_addr], rt_data=reg[rt_addr]; index 0 -> 0.
//  - Same-address on both read ports: both return identical data.
//  - Reset deasserted mid-cycle: first write accepted on the first posedge after
//    release; no partial state survives.
//  - X on WB_in[0] is not masked; the bench must drive it known out of reset.
// CONFIGURATION
//  WB_BYPASS_EN defined: when wb_we=1 and a read index equals direccionRegistro_in,
//    that read port returns wb_data in the same cycle (write-before-read).
//    Index 0 is never bypassed.
//  WB_BYPASS_EN undefined: read ports return array contents only; the new value
//    appears the cycle after the write edge. The hazard unit must stall one extra
//    cycle for a WB->ID RAW hazard.
// STRUCTURE
//  - Shared package mips32_pkg: WB_REGWRITE=0, WB_MEMTOREG=1 bit indices,
//    REG_ZERO=5'd0, NUM_REGS=32.
//  - Sub-module wb_mux: 2:1 write-back select (datoLeido vs direccion) producing
//    wb_data. The register array, counter and bypass stay in wb_regfile.
// TESTING
//  1 Reset: pulse rst_n low mid-cycle after writes -> every rs/rt read 0 and
//    wr_count=0 without waiting for clk.
//  2 ALU write: WB=2'b01, direccion=32'h0000_1234, dest=5 -> after 1 edge, rs_addr=5
//    reads 32'h0000_1234 and wr_count=1.
//  3 Load write: WB=2'b11, datoLeido=32'hDEAD_BEEF, dest=31 -> rt_addr=31 reads
//    32'hDEAD_BEEF; direccion ignored.
//  4 $0 / no-write: WB=2'b01, dest=0, data=32'hFFFF_FFFF -> rs_addr=0 reads 0 and
//    wr_count is unchanged. WB=2'b10 to dest=7 -> reg7 is unchanged.
//  5 Bypass: write 32'hA5A5_A5A5 to reg 9 with rs_addr=rt_addr=9 in the same cycle ->
//    with WB_BYPASS_EN both read A5A5_A5A5 before the edge; without it they read the
//    old value until after the edge.
//  6 Counter wrap (CNT_W=4): 17 writes to nonzero regs -> wr_count=1.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions.
//   WB_REGWRITE / WB_MEMTOREG : bit positions inside the WB control bundle
//   REG_ZERO                  : index of the hard-wired zero register
//   NUM_REGS                  : architectural register count
package mips32_pkg;

  localparam int          WB_REGWRITE = 0;
  localparam int          WB_MEMTOREG = 1;
  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam int          NUM_REGS    = 32;

endpackage

// File: rtl/wb_mux.sv
// Write-back value select.
// Ports:
//   mem_to_reg    in   1          1 = load data, 0 = ALU result
//   datoLeido_in  in   SIZE_DATA  load data from MEM/WB
//   direccion_in  in   SIZE_DATA  ALU result from MEM/WB
//   wb_data       out  SIZE_DATA  selected write-back value
module wb_mux #(
  parameter int SIZE_DATA = 32
) (
  input  logic                 mem_to_reg,
  input  logic [SIZE_DATA-1:0] datoLeido_in,
  input  logic [SIZE_DATA-1:0] direccion_in,
  output logic [SIZE_DATA-1:0] wb_data
);

  assign wb_data = mem_to_reg ? datoLeido_in : direccion_in;

endmodule

// File: rtl/wb_regfile.sv
// MIPS32 write-back stage plus architectural register file.
// Selects the write-back value, commits it into the register file, serves two
// combinational read ports and counts committed writes.
// Optional feature macro: WB_BYPASS_EN -- when defined, a read port whose index
// matches the register being written this cycle returns wb_data directly
// (write-before-read); index 0 is never bypassed.
// Ports:
//   clk                   in   1          rising-edge clock
//   rst_n                 in   1          asynchronous active-low reset
//   WB_in                 in   S_WB       [0]=RegWrite, [1]=MemtoReg
//   datoLeido_in          in   SIZE_DATA  load data
//   direccion_in          in   SIZE_DATA  ALU result
//   direccionRegistro_in  in   SIZE_ADDR  destination register
//   rs_addr / rt_addr     in   SIZE_ADDR  read indices
//   rs_data / rt_data     out  SIZE_DATA  read data (combinational)
//   wb_data               out  SIZE_DATA  selected write-back value
//   wb_we                 out  1          effective write enable
//   wr_count              out  CNT_W      committed-write counter (wraps)
module wb_regfile
  import mips32_pkg::*;
#(
  parameter int S_WB      = 2,
  parameter int SIZE_DATA = 32,
  parameter int SIZE_ADDR = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [S_WB-1:0]      WB_in,
  input  logic [SIZE_DATA-1:0] datoLeido_in,
  input  logic [SIZE_DATA-1:0] direccion_in,
  input  logic [SIZE_ADDR-1:0] direccionRegistro_in,
  input  logic [SIZE_ADDR-1:0] rs_addr,
  input  logic [SIZE_ADDR-1:0] rt_addr,
  output logic [SIZE_DATA-1:0] rs_data,
  output logic [SIZE_DATA-1:0] rt_data,
  output logic [SIZE_DATA-1:0] wb_data,
  output logic                 wb_we,
  output logic [CNT_W-1:0]     wr_count
);

  localparam int DEPTH = 2**SIZE_ADDR;
  localparam logic [SIZE_ADDR-1:0] ZERO_IDX = SIZE_ADDR'(REG_ZERO);

  logic [SIZE_DATA-1:0] regs [0:DEPTH-1];

  wb_mux #(.SIZE_DATA(SIZE_DATA)) u_wb_mux (
    .mem_to_reg   (WB_in[WB_MEMTOREG]),
    .datoLeido_in (datoLeido_in),
    .direccion_in (direccion_in),
    .wb_data      (wb_data)
  );

  assign wb_we = WB_in[WB_REGWRITE] && (direccionRegistro_in != ZERO_IDX);

  // Entry 0 is only ever cleared; wb_we excludes it as a write target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (wb_we) begin
      regs[direccionRegistro_in] <= wb_data;
      wr_count <= wr_count + CNT_W'(1);
    end
  end

  always_comb begin
    rs_data = (rs_addr == ZERO_IDX) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == ZERO_IDX) ? '0 : regs[rt_addr];
`ifdef WB_BYPASS_EN
    // wb_we already implies a nonzero destination, so $0 cannot be bypassed.
    if (wb_we && (rs_addr == direccionRegistro_in)) rs_data = wb_data;
    if (wb_we && (rt_addr == direccionRegistro_in)) rt_data = wb_data;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  import mips32_pkg::*;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  WB_in = 2'b00;
  logic [31:0] datoLeido_in = '0;
  logic [31:0] direccion_in = '0;
  logic [4:0]  direccionRegistro_in = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_we;
  logic [CW-1:0] wr_count;

  wb_regfile #(.S_WB(2), .SIZE_DATA(32), .SIZE_ADDR(5), .CNT_W(CW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .WB_in                (WB_in),
    .datoLeido_in         (datoLeido_in),
    .direccion_in         (direccion_in),
    .direccionRegistro_in (direccionRegistro_in),
    .rs_addr              (rs_addr),
    .rt_addr              (rt_addr),
    .rs_data              (rs_data),
    .rt_data              (rt_data),
    .wb_data              (wb_data),
    .wb_we                (wb_we),
    .wr_count             (wr_count)
  );

  always #5 clk = ~clk;

  typedef enum int { S_RS, S_RT, S_WBD, S_WE, S_CNT } sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  event chk_ev;
  int   errors = 0;
  int   checks = 0;

  task automatic expect_val(input string nm, input sel_t sel, input logic [31:0] e);
    chk_t c;
    c.name = nm; c.sel = sel; c.exp = e;
    sb_q.push_back(c);
  endtask

  // Let combinational outputs settle, then hand the queued expectations to the monitor.
  task automatic present();
    #1;
    ->chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        c = sb_q.pop_front();
        case (c.sel)
          S_RS:    act = rs_data;
          S_RT:    act = rt_data;
          S_WBD:   act = wb_data;
          S_WE:    act = {31'b0, wb_we};
          default: act = 32'(wr_count);
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] pre9;
    // Reset state
    repeat (2) tick();
    rs_addr = 5'd0; rt_addr = 5'd5;
    expect_val("reset_rs0", S_RS, 32'h0);
    expect_val("reset_rt5", S_RT, 32'h0);
    expect_val("reset_cnt", S_CNT, 32'h0);
    present();
    #3 rst_n = 1'b1;

    // ALU write to r5
    WB_in = 2'b01; direccion_in = 32'h0000_1234; datoLeido_in = 32'h5555_5555;
    direccionRegistro_in = 5'd5; rs_addr = 5'd5;
    expect_val("alu_wbdata", S_WBD, 32'h0000_1234);
    expect_val("alu_we", S_WE, 32'h1);
`ifdef WB_BYPASS_EN
    expect_val("alu_pre_edge_rs5", S_RS, 32'h0000_1234);
`else
    expect_val("alu_pre_edge_rs5", S_RS, 32'h0);
`endif
    present();
    tick();
    WB_in = 2'b00;
    expect_val("alu_rs5", S_RS, 32'h0000_1234);
    expect_val("alu_cnt", S_CNT, 32'd1);
    present();

    // Load write to r31
    WB_in = 2'b11; datoLeido_in = 32'hDEAD_BEEF; direccion_in = 32'h1111_1111;
    direccionRegistro_in = 5'd31; rt_addr = 5'd31;
    expect_val("load_wbdata", S_WBD, 32'hDEAD_BEEF);
    present();
    tick();
    WB_in = 2'b00;
    expect_val("load_rt31", S_RT, 32'hDEAD_BEEF);
    expect_val("load_rs5_kept", S_RS, 32'h0000_1234);
    expect_val("load_cnt", S_CNT, 32'd2);
    present();

    // $0 write and RegWrite=0 write
    WB_in = 2'b01; direccion_in = 32'hFFFF_FFFF; direccionRegistro_in = 5'd0;
    rs_addr = 5'd0;
    expect_val("zero_we", S_WE, 32'h0);
    present();
    tick();
    expect_val("zero_rs0", S_RS, 32'h0);
    expect_val("zero_cnt", S_CNT, 32'd2);
    present();
    WB_in = 2'b10; datoLeido_in = 32'h7777_7777; direccionRegistro_in = 5'd7;
    rt_addr = 5'd7;
    expect_val("nowr_we", S_WE, 32'h0);
    present();
    tick();
    WB_in = 2'b00;
    expect_val("nowr_rt7", S_RT, 32'h0);
    expect_val("nowr_cnt", S_CNT, 32'd2);
    present();

    // Bypass: preload r9, then overwrite with both ports on r9
    pre9 = 32'h1111_2222;
    WB_in = 2'b01; direccion_in = pre9; direccionRegistro_in = 5'd9;
    tick();
    direccion_in = 32'hA5A5_A5A5; rs_addr = 5'd9; rt_addr = 5'd9;
`ifdef WB_BYPASS_EN
    expect_val("byp_pre_rs9", S_RS, 32'hA5A5_A5A5);
    expect_val("byp_pre_rt9", S_RT, 32'hA5A5_A5A5);
`else
    expect_val("byp_pre_rs9", S_RS, pre9);
    expect_val("byp_pre_rt9", S_RT, pre9);
`endif
    present();
    tick();
    WB_in = 2'b00;
    expect_val("byp_post_rs9", S_RS, 32'hA5A5_A5A5);
    expect_val("byp_post_rt9", S_RT, 32'hA5A5_A5A5);
    expect_val("byp_cnt", S_CNT, 32'd4);
    present();

    // Async reset mid-cycle after writes
    #1 rst_n = 1'b0;
    rs_addr = 5'd5; rt_addr = 5'd31;
    expect_val("arst_rs5", S_RS, 32'h0);
    expect_val("arst_rt31", S_RT, 32'h0);
    expect_val("arst_cnt", S_CNT, 32'h0);
    present();
    // Writes ignored while held in reset
    WB_in = 2'b01; direccion_in = 32'h0000_0044; direccionRegistro_in = 5'd4;
    rs_addr = 5'd4;
    tick();
    expect_val("inrst_rs4", S_RS, 32'h0);
    expect_val("inrst_cnt", S_CNT, 32'h0);
    present();
    // Release mid-cycle; first edge afterwards commits
    #2 rst_n = 1'b1;
    tick();
    WB_in = 2'b00;
    expect_val("rel_rs4", S_RS, 32'h0000_0044);
    expect_val("rel_cnt", S_CNT, 32'd1);
    present();

    // Counter wrap: 17 writes after a fresh reset -> 17 mod 16 = 1
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      WB_in = 2'b01; direccion_in = 32'h100 + 32'(i);
      direccionRegistro_in = 5'(i + 1);
      tick();
    end
    WB_in = 2'b00;
    rs_addr = 5'd17; rt_addr = 5'd1;
    expect_val("wrap_cnt", S_CNT, 32'd1);
    expect_val("wrap_rs17", S_RS, 32'h0000_0110);
    expect_val("wrap_rt1", S_RT, 32'h0000_0100);
    present();

    #5;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    if (checks < NUM_REGS / 2) begin
      errors++;
      $display("FAIL check_count: got %0d expected at least %0d", checks, NUM_REGS / 2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
